// File: rtl/dot_pkg.sv
// Shared state encoding and width helpers for the streaming dot-product engine.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int lenWidth(input int maxBeats);
        return $clog2(maxBeats + 1);
    endfunction

    // Wide enough that summing LANES*MAX_BEATS full-width products never overflows.
    function automatic int accWidth(input int dataW, input int lanes, input int maxBeats);
        return 2 * dataW + $clog2(lanes * maxBeats);
    endfunction

endpackage

// File: rtl/dot_product_stream_if.sv
// Control, operand-stream and result-stream signals of dot_product_stream.
interface dot_product_stream_if #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 2,
    parameter int MAX_BEATS = 32
);
    import dot_pkg::*;

    localparam int LEN_W = lenWidth(MAX_BEATS);
    localparam int ACC_W = accWidth(DATA_W, LANES, MAX_BEATS);

    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_a;
    logic [LANES*DATA_W-1:0] in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_result;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_result
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_result
    );

endinterface

// File: rtl/dot_lane_mult.sv
// Combinational LANES-wide multiply and adder tree producing one beat's product sum.
// Build option: DOT_SIGNED_EN selects two's-complement operands (default unsigned).
module dot_lane_mult #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int ACC_W  = 22
) (
    input  logic [LANES*DATA_W-1:0] a_i,
    input  logic [LANES*DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]        sum_o
);

    logic [2*DATA_W-1:0] prod;

    // Operands are widened before multiplying so the low 2*DATA_W bits hold the exact product.
    always_comb begin
        sum_o = '0;
        prod  = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef DOT_SIGNED_EN
            prod  = $signed({{DATA_W{a_i[k*DATA_W+DATA_W-1]}}, a_i[k*DATA_W +: DATA_W]})
                  * $signed({{DATA_W{b_i[k*DATA_W+DATA_W-1]}}, b_i[k*DATA_W +: DATA_W]});
            sum_o = sum_o + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`else
            prod  = {{DATA_W{1'b0}}, a_i[k*DATA_W +: DATA_W]}
                  * {{DATA_W{1'b0}}, b_i[k*DATA_W +: DATA_W]};
            sum_o = sum_o + {{(ACC_W-2*DATA_W){1'b0}}, prod};
`endif
        end
    end

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot-product engine: FSM, beat counter, product pipeline register and accumulator.
// Build option: DOT_SIGNED_EN (handled in dot_lane_mult) makes the arithmetic signed.
module dot_product_stream
    import dot_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LANES     = 2,
    parameter int MAX_BEATS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dot_product_stream_if.slave  bus
);

    localparam int LEN_W = lenWidth(MAX_BEATS);
    localparam int ACC_W = accWidth(DATA_W, LANES, MAX_BEATS);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   prod_q, prod_d;
    logic               pv_q, pv_d;
    logic [ACC_W-1:0]   beatSum;

    dot_lane_mult #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) uLaneMult (
        .a_i   (bus.in_a),
        .b_i   (bus.in_b),
        .sum_o (beatSum)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            pv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            pv_q        <= pv_d;
        end
    end

    // The accumulator trails the product register by one cycle; DRAIN folds in the last product.
    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        acc_d          = acc_q;
        prod_d         = prod_q;
        pv_d           = pv_q;
        bus.busy       = (state_q != IDLE);
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_result = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    if (bus.len != '0) begin
                        remaining_d = bus.len;
                        state_d     = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (pv_q) begin
                    acc_d = acc_q + prod_q;
                end
                if (bus.in_valid) begin
                    prod_d      = beatSum;
                    pv_d        = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end else begin
                    pv_d = 1'b0;
                end
            end
            DRAIN: begin
                acc_d   = acc_q + prod_q;
                pv_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                bus.out_valid  = 1'b1;
                bus.out_result = acc_q;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dot_product_stream.sv
// Self-checking bench for dot_product_stream against a plain-arithmetic dot-product model.
// Honours DOT_SIGNED_EN so the model and the signed directed case follow the build option.
module tb_dot_product_stream;
    import dot_pkg::*;

    localparam int DATA_W    = 8;
    localparam int LANES     = 2;
    localparam int MAX_BEATS = 32;
    localparam int ACC_W     = accWidth(DATA_W, LANES, MAX_BEATS);
    localparam int LEN_W     = lenWidth(MAX_BEATS);
    localparam int MAX_ELEM  = LANES * MAX_BEATS;

    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;

    logic [DATA_W-1:0] aVal [MAX_ELEM];
    logic [DATA_W-1:0] bVal [MAX_ELEM];

    dot_product_stream_if #(.DATA_W(DATA_W), .LANES(LANES), .MAX_BEATS(MAX_BEATS)) bus ();

    dot_product_stream #(.DATA_W(DATA_W), .LANES(LANES), .MAX_BEATS(MAX_BEATS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: element-wise products summed as ordinary integers, then cut to ACC_W bits.
    function automatic logic [ACC_W-1:0] refDot(input int n);
        longint total;
        total = 0;
        for (int i = 0; i < n * LANES; i++) begin
`ifdef DOT_SIGNED_EN
            total += longint'($signed(aVal[i])) * longint'($signed(bVal[i]));
`else
            total += longint'(aVal[i]) * longint'(bVal[i]);
`endif
        end
        return total[ACC_W-1:0];
    endfunction

    task automatic driveBeat(input int beat);
        for (int k = 0; k < LANES; k++) begin
            bus.in_a[k*DATA_W +: DATA_W] = aVal[beat*LANES + k];
            bus.in_b[k*DATA_W +: DATA_W] = bVal[beat*LANES + k];
        end
    endtask

    task automatic fillBasic();
        for (int i = 0; i < 8; i++) begin
            aVal[i] = DATA_W'(i + 1);
            bVal[i] = DATA_W'(8 - i);
        end
    endtask

    task automatic fillRandom(input int n);
        for (int i = 0; i < n * LANES; i++) begin
            aVal[i] = DATA_W'($urandom);
            bVal[i] = DATA_W'($urandom);
        end
    endtask

    // gapMode: 0 in_valid held high, 1 toggled 1-0-1-0, 2 random.
    task automatic applyStimulus(input string tag, input int n, input int gapMode,
                                 input int holdCycles, input bit pulseStart,
                                 output logic [ACC_W-1:0] result);
        logic [ACC_W-1:0] expected;
        int beatIdx;
        int cycles;
        bit v;
        expected = refDot(n);
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(1));
        if (n == 0) begin
            checkOutput({tag, "_len0_valid"}, 64'(bus.out_valid), 64'(1));
        end else begin
            beatIdx = 0;
            cycles  = 0;
            while (beatIdx < n && cycles < 2000) begin
                checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
                case (gapMode)
                    0:       v = 1'b1;
                    1:       v = (cycles % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bus.in_valid = v;
                driveBeat(beatIdx);
                if (pulseStart && cycles == 1) begin
                    bus.start = 1'b1;
                    bus.len   = LEN_W'($urandom_range(1, MAX_BEATS));
                end
                if (v && bus.in_ready) beatIdx++;
                @(negedge clk);
                bus.start = 1'b0;
                cycles++;
            end
            checkOutput({tag, "_beats_taken"}, 64'(beatIdx), 64'(n));
            bus.in_valid = 1'b0;
            bus.in_a     = '0;
            bus.in_b     = '0;
            checkOutput({tag, "_drain_valid"}, 64'(bus.out_valid), 64'(0));
            checkOutput({tag, "_drain_ready"}, 64'(bus.in_ready), 64'(0));
            @(negedge clk);
            checkOutput({tag, "_latency_valid"}, 64'(bus.out_valid), 64'(1));
        end
        checkOutput({tag, "_result"}, 64'(bus.out_result), 64'(expected));
        result = bus.out_result;
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
            checkOutput({tag, "_hold_result"}, 64'(bus.out_result), 64'(expected));
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = LEN_W'(3);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        checkOutput({tag, "_after_valid"}, 64'(bus.out_valid), 64'(0));
        checkOutput({tag, "_after_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        logic [ACC_W-1:0] res;
        compareCount  = 0;
        mismatchCount = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'(0));
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(0));
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset_result", 64'(bus.out_result), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("idle_ignores_valid", 64'(bus.busy), 64'(0));
        bus.in_valid = 1'b0;

        fillBasic();
        applyStimulus("basic", 4, 0, 0, 1'b0, res);
        checkOutput("basic_value", 64'(res), 64'(120));
        applyStimulus("backpressure", 4, 1, 5, 1'b0, res);
        checkOutput("backpressure_value", 64'(res), 64'(120));

        for (int i = 0; i < MAX_ELEM; i++) begin
            aVal[i] = 8'hFF;
            bVal[i] = 8'hFF;
        end
        applyStimulus("max", MAX_BEATS, 0, 1, 1'b0, res);
`ifndef DOT_SIGNED_EN
        checkOutput("max_value", 64'(res), 64'(4161600));
`endif

        applyStimulus("len0", 0, 0, 2, 1'b0, res);
        fillBasic();
        applyStimulus("start_in_accum", 4, 0, 0, 1'b1, res);
        checkOutput("start_in_accum_value", 64'(res), 64'(120));

        bus.start = 1'b1;
        bus.len   = LEN_W'(4);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int beat = 0; beat < 2; beat++) begin
            driveBeat(beat);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", 64'(bus.busy), 64'(0));
        checkOutput("midreset_in_ready", 64'(bus.in_ready), 64'(0));
        checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("midreset_result", 64'(bus.out_result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        aVal[0] = 8'd3; aVal[1] = 8'd4;
        bVal[0] = 8'd5; bVal[1] = 8'd6;
        applyStimulus("after_reset", 1, 0, 0, 1'b0, res);
        checkOutput("after_reset_value", 64'(res), 64'(39));

`ifdef DOT_SIGNED_EN
        aVal[0] = 8'hFF; aVal[1] = 8'h80;
        bVal[0] = 8'd3;  bVal[1] = 8'h80;
        applyStimulus("signed", 1, 0, 0, 1'b0, res);
        checkOutput("signed_value", 64'(res), 64'(16381));
`endif

        for (int t = 0; t < 8; t++) begin
            int n;
            n = (t == 3) ? 0 : int'($urandom_range(1, MAX_BEATS));
            fillRandom(n);
            applyStimulus("random", n, int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
